// File: rtl/am2909_ctl.sv
// Next-address controller for an am2909 slice cascade: Am2910-style decode, loop counter, stack depth.
// Define AM2909_CTL_ERR_EN to build the sticky stack overflow/underflow flag; otherwise err is tied low.
module am2909_ctl #(
    parameter int CW    = 12,
    parameter int DEPTH = 4
) (
    input  logic          cp,
    input  logic          rst_n,
    input  logic [3:0]    i,
    input  logic          cc_n,
    input  logic          ccen_n,
    input  logic [CW-1:0] d,
    output logic [1:0]    s,
    output logic          fe_n,
    output logic          pup,
    output logic          za_n,
    output logic          re_n,
    output logic          pl_n,
    output logic          map_n,
    output logic          vect_n,
    output logic          cnt_z,
    output logic          full_n,
    output logic          err
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DMAX = DW'(DEPTH);

    typedef enum logic [3:0] {
        I_JZ   = 4'h0, I_CJS  = 4'h1, I_JMAP = 4'h2, I_CJP  = 4'h3,
        I_PUSH = 4'h4, I_JSRP = 4'h5, I_CJV  = 4'h6, I_JRP  = 4'h7,
        I_RFCT = 4'h8, I_RPCT = 4'h9, I_CRTN = 4'hA, I_CJPP = 4'hB,
        I_LDCT = 4'hC, I_LOOP = 4'hD, I_CONT = 4'hE, I_TWB  = 4'hF
    } instr_e;

    typedef enum logic [1:0] {
        S_UPC = 2'b00, S_AR = 2'b01, S_STK = 2'b10, S_D = 2'b11
    } src_e;

    instr_e         op;
    src_e           src;
    logic           pass;
    logic           push, pop, ld, dec, clr;
    logic           cnt_nz, full, empty;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  depth_q, depth_d;

    assign op     = instr_e'(i);
    assign pass   = ccen_n | ~cc_n;
    assign cnt_nz = |cnt_q;
    assign full   = (depth_q == DMAX);
    assign empty  = (depth_q == '0);
    assign cnt_z  = ~cnt_nz;
    assign full_n = ~full;
    assign s      = src;

    // Instruction decode; every action flag stays low while reset is held.
    always_comb begin
        src    = S_UPC;
        za_n   = 1'b1;
        pl_n   = 1'b0;
        map_n  = 1'b1;
        vect_n = 1'b1;
        push   = 1'b0;
        pop    = 1'b0;
        ld     = 1'b0;
        dec    = 1'b0;
        clr    = 1'b0;
        if (!rst_n) begin
            za_n = 1'b0;
        end else begin
            case (op)
                I_JZ: begin
                    za_n = 1'b0;
                    clr  = 1'b1;
                end
                I_CJS: if (pass) begin
                    src  = S_D;
                    push = 1'b1;
                end
                I_JMAP: begin
                    src   = S_D;
                    map_n = 1'b0;
                    pl_n  = 1'b1;
                end
                I_CJP: if (pass) src = S_D;
                I_PUSH: begin
                    push = 1'b1;
                    ld   = pass;
                end
                I_JSRP: begin
                    src  = pass ? S_D : S_AR;
                    push = 1'b1;
                end
                I_CJV: if (pass) begin
                    src    = S_D;
                    vect_n = 1'b0;
                    pl_n   = 1'b1;
                end
                I_JRP: src = pass ? S_D : S_AR;
                I_RFCT: begin
                    if (cnt_nz) begin
                        src = S_STK;
                        dec = 1'b1;
                    end else begin
                        pop = 1'b1;
                    end
                end
                I_RPCT: if (cnt_nz) begin
                    src = S_D;
                    dec = 1'b1;
                end
                I_CRTN: if (pass) begin
                    src = S_STK;
                    pop = 1'b1;
                end
                I_CJPP: if (pass) begin
                    src = S_D;
                    pop = 1'b1;
                end
                I_LDCT: ld = 1'b1;
                I_LOOP: begin
                    if (pass) pop = 1'b1;
                    else      src = S_STK;
                end
                I_CONT: ;
                I_TWB: begin
                    if (pass) begin
                        pop = 1'b1;
                    end else if (cnt_nz) begin
                        src = S_STK;
                        dec = 1'b1;
                    end else begin
                        src = S_D;
                        pop = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        fe_n = ~(push | pop);
        pup  = push;
        re_n = ~ld;
    end

    // Depth saturates / floors, but the slice still sees the push or pop.
    always_comb begin
        cnt_d   = cnt_q;
        depth_d = depth_q;
        if (ld)       cnt_d = d;
        else if (dec) cnt_d = cnt_q - CW'(1);
        if (clr)                depth_d = '0;
        else if (push && !full) depth_d = depth_q + DW'(1);
        else if (pop && !empty) depth_d = depth_q - DW'(1);
    end

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            depth_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            depth_q <= depth_d;
        end
    end

`ifdef AM2909_CTL_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (clr)                                err_d = 1'b0;
        else if ((push && full) || (pop && empty)) err_d = 1'b1;
    end

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_am2909_ctl.sv
// Scoreboarded bench for am2909_ctl: a driver pushes expected outputs from an abstract model,
// a negedge monitor pops and compares.
module tb_am2909_ctl;

    localparam int CW    = 12;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [1:0] s;
        logic fe_n, pup, za_n, re_n, pl_n, map_n, vect_n, cnt_z, full_n, err;
    } outs_t;

    logic          cp = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    i = 4'hE;
    logic          cc_n = 1'b1;
    logic          ccen_n = 1'b1;
    logic [CW-1:0] d = '0;
    logic [1:0]    s;
    logic          fe_n, pup, za_n, re_n, pl_n, map_n, vect_n, cnt_z, full_n, err;

    am2909_ctl #(.CW(CW), .DEPTH(DEPTH)) dut (
        .cp(cp), .rst_n(rst_n), .i(i), .cc_n(cc_n), .ccen_n(ccen_n), .d(d),
        .s(s), .fe_n(fe_n), .pup(pup), .za_n(za_n), .re_n(re_n), .pl_n(pl_n),
        .map_n(map_n), .vect_n(vect_n), .cnt_z(cnt_z), .full_n(full_n), .err(err)
    );

    always #5 cp = ~cp;

    outs_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    // Reference state: plain integers, updated as if the next clock edge had happened.
    int m_cnt = 0, m_depth = 0;
    bit m_err = 0;
`ifdef AM2909_CTL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    task automatic step(input bit r, input int op, input bit cc, input bit ccen, input int dv);
        outs_t e;
        int    src, stk;
        bit    load, decr, zero, pass, mapsel, vecsel;
        @(posedge cp);
        #1;
        rst_n = r; i = 4'(op); cc_n = cc; ccen_n = ccen; d = CW'(dv);
        pass = ccen | ~cc;
        src = 0; stk = 0; load = 0; decr = 0; zero = 0; mapsel = 0; vecsel = 0;
        if (!r) begin
            m_cnt = 0; m_depth = 0; m_err = 0;
        end else begin
            case (op)
                0:  zero = 1;
                1:  if (pass) begin src = 3; stk = 1; end
                2:  begin src = 3; mapsel = 1; end
                3:  if (pass) src = 3;
                4:  begin stk = 1; load = pass; end
                5:  begin src = pass ? 3 : 1; stk = 1; end
                6:  if (pass) begin src = 3; vecsel = 1; end
                7:  src = pass ? 3 : 1;
                8:  if (m_cnt != 0) begin src = 2; decr = 1; end else stk = -1;
                9:  if (m_cnt != 0) begin src = 3; decr = 1; end
                10: if (pass) begin src = 2; stk = -1; end
                11: if (pass) begin src = 3; stk = -1; end
                12: load = 1;
                13: if (pass) stk = -1; else src = 2;
                14: ;
                default: if (pass) stk = -1;
                         else if (m_cnt != 0) begin src = 2; decr = 1; end
                         else begin src = 3; stk = -1; end
            endcase
        end
        e.s      = 2'(src);
        e.fe_n   = (stk == 0);
        e.pup    = (stk > 0);
        e.za_n   = r && !zero;
        e.re_n   = !load;
        e.pl_n   = mapsel || vecsel;
        e.map_n  = !mapsel;
        e.vect_n = !vecsel;
        e.cnt_z  = (m_cnt == 0);
        e.full_n = (m_depth != DEPTH);
        e.err    = m_err;
        exp_q.push_back(e);
        if (r) begin
            if (ERR_EN && ((stk > 0 && m_depth == DEPTH) || (stk < 0 && m_depth == 0))) m_err = 1;
            if (zero) begin m_depth = 0; m_err = 0; end
            m_depth += stk;
            if (m_depth > DEPTH) m_depth = DEPTH;
            if (m_depth < 0) m_depth = 0;
            if (load) m_cnt = dv % (1 << CW);
            else if (decr) m_cnt = m_cnt - 1;
        end
    endtask

    always @(negedge cp) begin
        outs_t a, e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = '{s, fe_n, pup, za_n, re_n, pl_n, map_n, vect_n, cnt_z, full_n, err};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outs vec %0d i=%h rst_n=%b: got s=%b fe_n=%b pup=%b za_n=%b re_n=%b pl/map/vect=%b%b%b cnt_z=%b full_n=%b err=%b, want s=%b fe_n=%b pup=%b za_n=%b re_n=%b pl/map/vect=%b%b%b cnt_z=%b full_n=%b err=%b",
                         vectors, i, rst_n, a.s, a.fe_n, a.pup, a.za_n, a.re_n, a.pl_n, a.map_n, a.vect_n,
                         a.cnt_z, a.full_n, a.err, e.s, e.fe_n, e.pup, e.za_n, e.re_n, e.pl_n, e.map_n,
                         e.vect_n, e.cnt_z, e.full_n, e.err);
            end
        end
    end

    initial begin
        // Reset held, then CONT
        repeat (3) step(0, 14, 1, 1, 0);
        repeat (2) step(1, 14, 1, 1, 0);
        // LDCT 3 then RPCT x4
        step(1, 12, 1, 1, 3);
        repeat (4) step(1, 9, 1, 1, 'h100);
        step(1, 14, 1, 1, 0);
        // CJS pass, CJS fail, CRTN pass
        step(1, 1, 0, 1, 0);
        step(1, 1, 1, 0, 0);
        step(1, 10, 0, 0, 0);
        step(1, 14, 1, 1, 0);
        // Five CJS passes overflow, then JZ
        repeat (5) step(1, 1, 1, 1, 5);
        step(1, 14, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        step(1, 14, 1, 1, 0);
        // Pop at empty (underflow)
        step(1, 10, 0, 0, 0);
        step(1, 14, 1, 1, 0);
        step(1, 0, 1, 1, 0);
        // PUSH pass d=2, TWB fail x3
        step(1, 4, 0, 0, 2);
        repeat (3) step(1, 15, 1, 0, 0);
        step(1, 14, 1, 1, 0);
        // JMAP, CJV pass, CJV fail
        step(1, 2, 1, 1, 0);
        step(1, 6, 0, 0, 0);
        step(1, 6, 1, 0, 0);
        // Reset mid-LOOP
        step(1, 12, 1, 1, 7);
        step(1, 1, 1, 1, 0);
        step(1, 13, 1, 0, 0);
        step(0, 13, 1, 0, 0);
        step(1, 14, 1, 1, 0);
        // Randomized instruction mix
        for (int n = 0; n < 400; n++) begin
            int dv;
            dv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (1 << CW) - 1))
                                             : int'($urandom_range(0, 5));
            step(($urandom_range(0, 39) != 0), int'($urandom_range(0, 15)),
                 1'($urandom), 1'($urandom), dv);
        end
        repeat (2) @(posedge cp);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors never checked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
